// File: rtl/p251_pkg.sv
// Shared constants and types for the GF(251) arithmetic datapath.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package p251_pkg;

    localparam int P    = 251;
    localparam int EL_W = 8;
    localparam int PR_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } state_e;

endpackage

// File: rtl/p251_red.sv
// Reduces a 16-bit value to its canonical residue mod 251.
// Latency: combinational; o_done simply mirrors i_start.
// Backpressure: none, accepts a value every cycle.
module p251_red
    import p251_pkg::*;
(
    input  logic            i_start,
    input  logic [PR_W-1:0] i_x,
    output logic [EL_W-1:0] o_r,
    output logic            o_done
);

    // 256 == 5 (mod 251): fold the high byte twice, then one conditional subtract.
    logic [10:0] fold1;
    logic [8:0]  fold2;
    logic [8:0]  fold2_sub;

    // Two folds bring any 16-bit input below 291, so one subtract finishes the job.
    always_comb begin
        fold1     = {3'b000, i_x[7:0]} + (11'(i_x[15:8]) * 11'd5);
        fold2     = {1'b0, fold1[7:0]} + (9'(fold1[10:8]) * 9'd5);
        fold2_sub = fold2 - 9'(P);
        o_r       = fold2[7:0];
        if (fold2 >= 9'(P)) begin
            o_r = fold2_sub[7:0];
        end
    end

    assign o_done = i_start;

endmodule

// File: rtl/p251_dot.sv
// Streaming inner product sum(a_i*b_i) mod 251 with a saturating term counter.
// Latency: last beat at edge T -> o_c written at T+1, o_done high the following cycle.
// Backpressure: o_ready high only in RUN; IDLE and the one-cycle FLUSH refuse pairs.
module p251_dot
    import p251_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic             i_valid,
    input  logic             i_last,
    input  logic [EL_W-1:0]  i_a,
    input  logic [EL_W-1:0]  i_b,
    output logic             o_ready,
    output logic [EL_W-1:0]  o_c,
    output logic             o_done,
    output logic [CNT_W-1:0] o_cnt
);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [EL_W-1:0]   acc_q, acc_d;
    logic [PR_W-1:0]   p_q, p_d;
    logic              p_vld_q, p_vld_d;
    logic              p_last_q, p_last_d;
    logic [EL_W-1:0]   c_q, c_d;
    logic              done_q, done_d;

    logic              beat;
    logic              start_go;
    logic [PR_W-1:0]   sum;
    logic [EL_W-1:0]   red_r;
    logic              red_done_unused;

    // FSM next state and handshake: start only from IDLE, FLUSH drains stage 1.
    always_comb begin
        state_d  = state_q;
        o_ready  = 1'b0;
        start_go = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    start_go = 1'b1;
                    state_d  = ST_RUN;
                end
            end
            ST_RUN: begin
                o_ready = 1'b1;
                if (i_valid && i_last) begin
                    state_d = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign beat = i_valid & o_ready;

    // Stage 1: register the raw 16-bit product with its valid/last tags.
    always_comb begin
        p_d      = p_q;
        p_vld_d  = beat;
        p_last_d = beat & i_last;
        if (beat) begin
            p_d = 16'(i_a) * 16'(i_b);
        end
    end

    // acc < 251 and p <= 65025, so the sum stays within 16 bits.
    assign sum = 16'(acc_q) + p_q;

    p251_red u_red (
        .i_start (1'b1),
        .i_x     (sum),
        .o_r     (red_r),
        .o_done  (red_done_unused)
    );

    // Stage 2: fold the product into the accumulator; publish the result on the last term.
    always_comb begin
        acc_d  = acc_q;
        c_d    = c_q;
        done_d = 1'b0;
        if (start_go) begin
            acc_d = '0;
        end else if (p_vld_q) begin
            acc_d = red_r;
        end
        if (p_vld_q && p_last_q) begin
            c_d    = red_r;
            done_d = 1'b1;
        end
    end

    // Term counter: cleared on start, counts beats, sticks at all-ones.
    always_comb begin
        cnt_d = cnt_q;
        if (start_go) begin
            cnt_d = '0;
        end else if (beat && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // State registers; reset aborts any vector in flight without a done pulse.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            p_q      <= '0;
            p_vld_q  <= 1'b0;
            p_last_q <= 1'b0;
            c_q      <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            p_q      <= p_d;
            p_vld_q  <= p_vld_d;
            p_last_q <= p_last_d;
            c_q      <= c_d;
            done_q   <= done_d;
        end
    end

    assign o_c    = c_q;
    assign o_done = done_q;
    assign o_cnt  = cnt_q;

endmodule

// File: tb/tb_p251_dot.sv
// Self-checking bench for p251_dot against an arithmetic inner-product model.
// Latency: checks o_done two cycles after the last beat.
// Backpressure: checks o_ready stays high throughout RUN, including gaps.
module tb_p251_dot;

    localparam int CNT_W = 16;

    logic             i_clk = 1'b0;
    logic             i_rst;
    logic             i_start;
    logic             i_valid;
    logic             i_last;
    logic [7:0]       i_a;
    logic [7:0]       i_b;
    logic             o_ready;
    logic [7:0]       o_c;
    logic             o_done;
    logic [CNT_W-1:0] o_cnt;

    int total = 0;
    int bad   = 0;

    logic [7:0] qa[$];
    logic [7:0] qb[$];

    logic [7:0]       r_c;
    logic [CNT_W-1:0] r_cnt;
    int               r_lat;
    int               r_rdy_bad;

    always #5 i_clk = ~i_clk;

    p251_dot #(.CNT_W(CNT_W)) dut (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_start (i_start),
        .i_valid (i_valid),
        .i_last  (i_last),
        .i_a     (i_a),
        .i_b     (i_b),
        .o_ready (o_ready),
        .o_c     (o_c),
        .o_done  (o_done),
        .o_cnt   (o_cnt)
    );

    // Reference: plain integer inner product reduced mod 251.
    function automatic int model_dot();
        int s = 0;
        foreach (qa[i]) s = (s + int'(qa[i]) * int'(qb[i])) % 251;
        return s;
    endfunction

    function automatic int model_cnt();
        return (qa.size() > 65535) ? 65535 : qa.size();
    endfunction

    // Drive qa/qb as one vector starting from IDLE at a negedge; returns at the
    // negedge where o_done is seen (lat = negedges counted from last-beat drive).
    task automatic run_vec(input int gap_pct, input int poke_idx,
                           output logic [7:0] c, output logic [CNT_W-1:0] cnt,
                           output int lat, output int rdy_bad);
        int idx = 0;
        lat     = -1;
        rdy_bad = 0;
        i_start = 1'b1;
        @(negedge i_clk);
        i_start = 1'b0;
        while (idx < qa.size()) begin
            if (o_ready !== 1'b1) rdy_bad++;
            i_start = (poke_idx == idx);
            if (int'($urandom_range(99)) < gap_pct) begin
                i_valid = 1'b0;
                i_last  = 1'($urandom_range(1));
                i_a     = 8'($urandom);
                i_b     = 8'($urandom);
            end else begin
                i_valid = 1'b1;
                i_a     = qa[idx];
                i_b     = qb[idx];
                i_last  = (idx == qa.size() - 1);
                idx++;
            end
            @(negedge i_clk);
        end
        i_valid = 1'b0;
        i_last  = 1'b0;
        i_start = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            if (o_done === 1'b1) begin
                lat = k;
                break;
            end
            @(negedge i_clk);
        end
        c   = o_c;
        cnt = o_cnt;
    endtask

    task automatic test_reset();
        i_rst = 1'b1; i_start = 0; i_valid = 0; i_last = 0; i_a = 0; i_b = 0;
        repeat (3) @(negedge i_clk);
        i_rst = 1'b0;
        @(negedge i_clk);
        total++; if (o_ready !== 1'b0) begin bad++; $display("FAIL reset_ready: got %0d want 0", o_ready); end
        total++; if (o_c !== 8'd0) begin bad++; $display("FAIL reset_c: got %0d want 0", o_c); end
        total++; if (o_done !== 1'b0) begin bad++; $display("FAIL reset_done: got %0d want 0", o_done); end
        total++; if (o_cnt !== 16'd0) begin bad++; $display("FAIL reset_cnt: got %0d want 0", o_cnt); end
    endtask

    task automatic test_single();
        qa = '{8'd250}; qb = '{8'd250};
        run_vec(0, -1, r_c, r_cnt, r_lat, r_rdy_bad);
        total++; if (r_c !== 8'd1) begin bad++; $display("FAIL single_c: got %0d want 1", r_c); end
        total++; if (r_cnt !== 16'd1) begin bad++; $display("FAIL single_cnt: got %0d want 1", r_cnt); end
        total++; if (r_lat != 2) begin bad++; $display("FAIL single_latency: got %0d want 2", r_lat); end
        @(negedge i_clk);
        total++; if (o_done !== 1'b0) begin bad++; $display("FAIL single_done_pulse: got %0d want 0", o_done); end
        total++; if (o_c !== 8'd1) begin bad++; $display("FAIL single_c_hold: got %0d want 1", o_c); end
    endtask

    task automatic test_gaps();
        qa = '{8'd250, 8'd250, 8'd250, 8'd250}; qb = qa;
        run_vec(50, -1, r_c, r_cnt, r_lat, r_rdy_bad);
        total++; if (r_c !== 8'd4) begin bad++; $display("FAIL gaps_c: got %0d want 4", r_c); end
        total++; if (r_cnt !== 16'd4) begin bad++; $display("FAIL gaps_cnt: got %0d want 4", r_cnt); end
        total++; if (r_rdy_bad != 0) begin bad++; $display("FAIL gaps_ready: low cycles %0d want 0", r_rdy_bad); end
        @(negedge i_clk);
    endtask

    task automatic test_back_to_back();
        qa.delete(); qb.delete();
        for (int i = 0; i < 251; i++) begin qa.push_back(8'd1); qb.push_back(8'd1); end
        run_vec(0, -1, r_c, r_cnt, r_lat, r_rdy_bad);
        total++; if (r_c !== 8'd0) begin bad++; $display("FAIL b2b_first_c: got %0d want 0", r_c); end
        total++; if (r_cnt !== 16'd251) begin bad++; $display("FAIL b2b_first_cnt: got %0d want 251", r_cnt); end
        qa = '{8'd255}; qb = '{8'd255};
        run_vec(0, -1, r_c, r_cnt, r_lat, r_rdy_bad);
        total++; if (r_c !== 8'd16) begin bad++; $display("FAIL b2b_second_c: got %0d want 16", r_c); end
        total++; if (r_cnt !== 16'd1) begin bad++; $display("FAIL b2b_second_cnt: got %0d want 1", r_cnt); end
        total++; if (r_rdy_bad != 0) begin bad++; $display("FAIL b2b_ready: low cycles %0d want 0", r_rdy_bad); end
        total++; if (r_lat != 2) begin bad++; $display("FAIL b2b_latency: got %0d want 2", r_lat); end
        @(negedge i_clk);
    endtask

    task automatic test_zero_start();
        int exp_c;
        qa = '{8'd0, 8'd0, 8'd0}; qb = qa;
        run_vec(0, 1, r_c, r_cnt, r_lat, r_rdy_bad);
        total++; if (r_c !== 8'd0) begin bad++; $display("FAIL zero_c: got %0d want 0", r_c); end
        total++; if (r_cnt !== 16'd3) begin bad++; $display("FAIL zero_cnt: got %0d want 3", r_cnt); end
        @(negedge i_clk);
        qa.delete(); qb.delete();
        for (int i = 0; i < 6; i++) begin
            qa.push_back(8'($urandom_range(1, 255)));
            qb.push_back(8'($urandom_range(1, 255)));
        end
        exp_c = model_dot();
        run_vec(20, 3, r_c, r_cnt, r_lat, r_rdy_bad);
        total++; if (r_c !== 8'(exp_c)) begin bad++; $display("FAIL restart_ignored_c: got %0d want %0d", r_c, exp_c); end
        total++; if (r_cnt !== 16'd6) begin bad++; $display("FAIL restart_ignored_cnt: got %0d want 6", r_cnt); end
        @(negedge i_clk);
    endtask

    task automatic test_abort();
        int dones = 0;
        i_start = 1'b1;
        @(negedge i_clk);
        i_start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            i_valid = 1'b1; i_last = 1'b0;
            i_a = 8'($urandom); i_b = 8'($urandom);
            @(negedge i_clk);
        end
        i_valid = 1'b0;
        i_rst = 1'b1;
        #1;
        total++; if (o_ready !== 1'b0) begin bad++; $display("FAIL abort_ready: got %0d want 0", o_ready); end
        total++; if (o_cnt !== 16'd0) begin bad++; $display("FAIL abort_cnt: got %0d want 0", o_cnt); end
        total++; if (o_c !== 8'd0) begin bad++; $display("FAIL abort_c: got %0d want 0", o_c); end
        @(negedge i_clk);
        i_rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (o_done === 1'b1) dones++;
            @(negedge i_clk);
        end
        total++; if (dones != 0) begin bad++; $display("FAIL abort_no_done: got %0d pulses want 0", dones); end
        qa = '{8'd2}; qb = '{8'd3};
        run_vec(0, -1, r_c, r_cnt, r_lat, r_rdy_bad);
        total++; if (r_c !== 8'd6) begin bad++; $display("FAIL abort_fresh_c: got %0d want 6", r_c); end
        total++; if (r_cnt !== 16'd1) begin bad++; $display("FAIL abort_fresh_cnt: got %0d want 1", r_cnt); end
        @(negedge i_clk);
    endtask

    task automatic test_random();
        int n, exp_c, exp_n;
        for (int v = 0; v < 6; v++) begin
            qa.delete(); qb.delete();
            n = int'($urandom_range(1, 1000));
            for (int i = 0; i < n; i++) begin
                qa.push_back(8'($urandom));
                qb.push_back(8'($urandom));
            end
            exp_c = model_dot();
            exp_n = model_cnt();
            run_vec(20, -1, r_c, r_cnt, r_lat, r_rdy_bad);
            total++; if (r_c !== 8'(exp_c)) begin bad++; $display("FAIL random_c[%0d]: got %0d want %0d", v, r_c, exp_c); end
            total++; if (r_cnt !== 16'(exp_n)) begin bad++; $display("FAIL random_cnt[%0d]: got %0d want %0d", v, r_cnt, exp_n); end
            total++; if (r_lat != 2) begin bad++; $display("FAIL random_latency[%0d]: got %0d want 2", v, r_lat); end
            repeat ($urandom_range(1, 2)) @(negedge i_clk);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_gaps();
        test_back_to_back();
        test_zero_start();
        test_abort();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached, bad=%0d", bad);
        $fatal(1);
    end

endmodule
